// File: rtl/qkd_pkg.sv
// Shared definitions for the per-block QKD event counter: class codes,
// snapshot count widths and the reporting FSM state type.
package qkd_pkg;

  localparam logic [1:0] CLS_VAC = 2'b00;
  localparam logic [1:0] CLS_V   = 2'b01;
  localparam logic [1:0] CLS_U   = 2'b10;
  localparam logic [1:0] CLS_INV = 2'b11;

  localparam int unsigned NV_W = 21;
  localparam int unsigned NU_W = 25;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAK  = 3'd1,
    S_START = 3'd2,
    S_WAITB = 3'd3,
    S_BUSY  = 3'd4
  } state_e;

endpackage

// File: rtl/qkd_cnt_accum_if.sv
// Pulse stream, leak strobe, estimator handshake and snapshot bus between
// the sifting front end / estimator (master) and the block counter (slave).
interface qkd_cnt_accum_if;
  import qkd_pkg::*;

  logic              i_evt_vld;
  logic [1:0]        i_cls;
  logic              i_det;
  logic              i_err;
  logic [31:0]       i_nleak;
  logic              i_nleak_vld;
  logic              i_est_busy;
  logic [NV_W-1:0]   o_nv;
  logic [NV_W-1:0]   o_no;
  logic [NV_W-1:0]   o_mv;
  logic [NV_W-1:0]   o_mo;
  logic [NU_W-1:0]   o_nu;
  logic [31:0]       o_nleak;
  logic              o_start;
  logic              o_ovf;
  logic              o_drop;
  logic              o_timeout;

  modport master (
    output i_evt_vld, i_cls, i_det, i_err, i_nleak, i_nleak_vld, i_est_busy,
    input  o_nv, o_no, o_mv, o_mo, o_nu, o_nleak, o_start, o_ovf, o_drop, o_timeout
  );

  modport slave (
    input  i_evt_vld, i_cls, i_det, i_err, i_nleak, i_nleak_vld, i_est_busy,
    output o_nv, o_no, o_mv, o_mo, o_nu, o_nleak, o_start, o_ovf, o_drop, o_timeout
  );

endinterface

// File: rtl/sat_cnt.sv
// Saturating event counter with sticky saturation flag. The next value is
// exported so a snapshot can include the increment of the current cycle.
module sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_nxt_o,
  output logic         sat_nxt_o
);

  logic [W-1:0] cnt_q;
  logic         sat_q;
  logic         at_max;

  // An increment arriving at all-ones is lost; that loss is what flags saturation.
  assign at_max    = &cnt_q;
  assign cnt_nxt_o = (en_i && !at_max) ? cnt_q + W'(1) : cnt_q;
  assign sat_nxt_o = sat_q | (en_i & at_max);

  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt_o;
      sat_q <= sat_nxt_o;
    end
  end

endmodule

// File: rtl/qkd_cnt_accum.sv
// Accumulates per-class detection/error counts over fixed-length blocks,
// snapshots them at block end and hands them to the estimator with a start pulse.
module qkd_cnt_accum
  import qkd_pkg::*;
#(
  parameter logic [31:0] BLK_LEN = 32'd1000000,
  parameter int unsigned START_W = 4,
  parameter logic [15:0] BUSY_TO = 16'd1024,
  parameter int unsigned NV_CW   = NV_W,
  parameter int unsigned NU_CW   = NU_W
) (
  input logic            clk,
  input logic            rst,
  qkd_cnt_accum_if.slave acc_if
);

  logic             accept, det_ok, blk_end, clr;
  logic             en_nv, en_nu, en_no, en_mv, en_mo;
  logic [NV_CW-1:0] nv_nxt, no_nxt, mv_nxt, mo_nxt;
  logic [NU_CW-1:0] nu_nxt;
  logic             sat_nv, sat_nu, sat_no, sat_mv, sat_mo;
  logic [31:0]      pcnt_q;

  state_e           state_q, state_d;
  logic [31:0]      st_cnt_q, st_cnt_d;
  logic [15:0]      to_cnt_q, to_cnt_d;
  logic             timeout_d, timeout_q, drop_q, ovf_q;
  logic [NV_W-1:0]  nv_q, no_q, mv_q, mo_q;
  logic [NU_W-1:0]  nu_q;
  logic [31:0]      nleak_q;
  logic             snap_ld, leak_ld;

  assign accept  = acc_if.i_evt_vld && (acc_if.i_cls != CLS_INV);
  assign det_ok  = accept && acc_if.i_det;
  assign en_nv   = det_ok && (acc_if.i_cls == CLS_V);
  assign en_nu   = det_ok && (acc_if.i_cls == CLS_U);
  assign en_no   = det_ok && (acc_if.i_cls == CLS_VAC);
  assign en_mv   = en_nv && acc_if.i_err;
  assign en_mo   = en_no && acc_if.i_err;
  assign blk_end = accept && (pcnt_q == BLK_LEN - 32'd1);
  // Counters clear on the ending edge; the snapshot takes their next values instead.
  assign clr     = rst || blk_end;

  sat_cnt #(.W(NV_CW)) u_cnt_nv (.clk(clk), .clr_i(clr), .en_i(en_nv), .cnt_nxt_o(nv_nxt), .sat_nxt_o(sat_nv));
  sat_cnt #(.W(NU_CW)) u_cnt_nu (.clk(clk), .clr_i(clr), .en_i(en_nu), .cnt_nxt_o(nu_nxt), .sat_nxt_o(sat_nu));
  sat_cnt #(.W(NV_CW)) u_cnt_no (.clk(clk), .clr_i(clr), .en_i(en_no), .cnt_nxt_o(no_nxt), .sat_nxt_o(sat_no));
  sat_cnt #(.W(NV_CW)) u_cnt_mv (.clk(clk), .clr_i(clr), .en_i(en_mv), .cnt_nxt_o(mv_nxt), .sat_nxt_o(sat_mv));
  sat_cnt #(.W(NV_CW)) u_cnt_mo (.clk(clk), .clr_i(clr), .en_i(en_mo), .cnt_nxt_o(mo_nxt), .sat_nxt_o(sat_mo));

  always_ff @(posedge clk) begin
    if (clr) begin
      pcnt_q <= '0;
    end else if (accept) begin
      pcnt_q <= pcnt_q + 32'd1;
    end
  end

  assign snap_ld = blk_end && (state_q == S_IDLE);
  assign leak_ld = acc_if.i_nleak_vld && (state_q == S_LEAK);

  always_comb begin
    state_d   = state_q;
    st_cnt_d  = st_cnt_q;
    to_cnt_d  = to_cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (blk_end) state_d = S_LEAK;
      end
      S_LEAK: begin
        if (acc_if.i_nleak_vld) begin
          state_d  = S_START;
          st_cnt_d = '0;
        end
      end
      S_START: begin
        if (st_cnt_q == 32'(START_W - 1)) begin
          state_d  = S_WAITB;
          to_cnt_d = '0;
        end else begin
          st_cnt_d = st_cnt_q + 32'd1;
        end
      end
      S_WAITB: begin
        if (acc_if.i_est_busy) begin
          state_d = S_BUSY;
        end else if (to_cnt_q == BUSY_TO - 16'd1) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      S_BUSY: begin
        if (!acc_if.i_est_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      st_cnt_q  <= '0;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
      drop_q    <= 1'b0;
      ovf_q     <= 1'b0;
      nv_q      <= '0;
      nu_q      <= '0;
      no_q      <= '0;
      mv_q      <= '0;
      mo_q      <= '0;
      nleak_q   <= '0;
    end else begin
      state_q   <= state_d;
      st_cnt_q  <= st_cnt_d;
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
      drop_q    <= blk_end && (state_q != S_IDLE);
      if (snap_ld) begin
        nv_q  <= NV_W'(nv_nxt);
        nu_q  <= NU_W'(nu_nxt);
        no_q  <= NV_W'(no_nxt);
        mv_q  <= NV_W'(mv_nxt);
        mo_q  <= NV_W'(mo_nxt);
        ovf_q <= sat_nv | sat_nu | sat_no | sat_mv | sat_mo;
      end
      if (leak_ld) nleak_q <= acc_if.i_nleak;
    end
  end

  assign acc_if.o_nv      = nv_q;
  assign acc_if.o_nu      = nu_q;
  assign acc_if.o_no      = no_q;
  assign acc_if.o_mv      = mv_q;
  assign acc_if.o_mo      = mo_q;
  assign acc_if.o_ovf     = ovf_q;
  assign acc_if.o_nleak   = nleak_q;
  assign acc_if.o_start   = (state_q == S_START);
  assign acc_if.o_drop    = drop_q;
  assign acc_if.o_timeout = timeout_q;

endmodule

// File: tb/tb_qkd_cnt_accum.sv
// Bench for qkd_cnt_accum: directed scenarios plus a randomized run, with the
// bench acting as estimator and predicting outputs from edge-numbered timelines.
module tb_qkd_cnt_accum;
  import qkd_pkg::*;

  localparam logic [31:0] BLK     = 32'd8;
  localparam int          SW      = 4;
  localparam int          TO      = 16;
  localparam int          CW      = 3;
  localparam int          MAXC    = (1 << CW) - 1;
  localparam int          FAR     = -1000;

  logic clk, rst;
  qkd_cnt_accum_if bus();

  qkd_cnt_accum #(
    .BLK_LEN(BLK), .START_W(SW), .BUSY_TO(16'(TO)), .NV_CW(CW), .NU_CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .acc_if(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  // Reporter timeline in edge numbers: report R, leak L, busy [B,Bend), idle after F.
  int R = FAR, L = FAR, B = FAR, Bend = FAR, F = 0;
  bit use_to = 1'b0;
  logic [31:0] leak_val = '0;
  int b_pc = 0, b_nv = 0, b_nu = 0, b_no = 0, b_mv = 0, b_mo = 0;
  logic [31:0] e_nv, e_nu, e_no, e_mv, e_mo, e_nleak;
  logic e_ovf, e_start, e_drop, e_to;
  int kn_dl = 0, kn_db = 0, kn_h = 0, kn_to = -1, spur_pct = 0;
  bit kn_leak_en = 1'b0;
  logic [31:0] kn_leak = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic model_reset();
    {e_nv, e_nu, e_no, e_mv, e_mo, e_nleak} = '0;
    e_ovf = 0; e_start = 0; e_drop = 0; e_to = 0;
    b_pc = 0; b_nv = 0; b_nu = 0; b_no = 0; b_mv = 0; b_mo = 0;
    R = FAR; L = FAR; B = FAR; Bend = FAR; F = 0; use_to = 0;
  endtask

  task automatic report(input int k);
    int dl, db, h;
    e_nv = sat(b_nv); e_nu = sat(b_nu); e_no = sat(b_no);
    e_mv = sat(b_mv); e_mo = sat(b_mo);
    e_ovf = (b_nv > MAXC) || (b_nu > MAXC) || (b_no > MAXC) || (b_mv > MAXC) || (b_mo > MAXC);
    dl = (kn_dl > 0) ? kn_dl : int'($urandom_range(1, 4));
    db = (kn_db > 0) ? kn_db : int'($urandom_range(1, TO));
    h  = (kn_h > 0) ? kn_h : int'($urandom_range(1, 8));
    use_to = (kn_to >= 0) ? (kn_to != 0) : ($urandom_range(0, 99) < 15);
    leak_val = kn_leak_en ? kn_leak : $urandom;
    R = k;
    L = k + dl;
    if (use_to) begin
      B = FAR; Bend = FAR; F = L + SW + TO;
    end else begin
      B = L + SW + db; Bend = B + h; F = Bend;
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [1:0] c, input logic d, input logic e);
    int k;
    logic strobe;
    logic [31:0] sval;
    k = cyc + 1;
    strobe = 1'b0;
    sval = $urandom;
    if (k == L) begin
      strobe = 1'b1; sval = leak_val;
    end else if (!(k > R && k <= L) && ($urandom_range(0, 99) < spur_pct)) begin
      strobe = 1'b1;
    end
    rst = r;
    bus.i_evt_vld = v; bus.i_cls = c; bus.i_det = d; bus.i_err = e;
    bus.i_nleak_vld = strobe; bus.i_nleak = sval;
    bus.i_est_busy = !use_to && (k >= B) && (k < Bend);
    e_drop = 0; e_to = 0;
    if (r) begin
      model_reset();
    end else begin
      if (k == L) e_nleak = leak_val;
      if (use_to && k == L + SW + TO) e_to = 1;
      if (v && c != 2'b11) begin
        b_pc++;
        if (d) begin
          case (c)
            2'b01: begin b_nv++; if (e) b_mv++; end
            2'b10: b_nu++;
            2'b00: begin b_no++; if (e) b_mo++; end
            default: ;
          endcase
        end
        if (b_pc == int'(BLK)) begin
          if (k > F) report(k);
          else e_drop = 1;
          b_pc = 0; b_nv = 0; b_nu = 0; b_no = 0; b_mv = 0; b_mo = 0;
        end
      end
    end
    e_start = (k >= L) && (k < L + SW);
    @(posedge clk);
    #1;
    cyc = k;
    chk("nv", 32'(bus.o_nv), e_nv);
    chk("nu", 32'(bus.o_nu), e_nu);
    chk("no", 32'(bus.o_no), e_no);
    chk("mv", 32'(bus.o_mv), e_mv);
    chk("mo", 32'(bus.o_mo), e_mo);
    chk("ovf", 32'(bus.o_ovf), 32'(e_ovf));
    chk("nleak", bus.o_nleak, e_nleak);
    chk("start", 32'(bus.o_start), 32'(e_start));
    chk("drop", 32'(bus.o_drop), 32'(e_drop));
    chk("timeout", 32'(bus.o_timeout), 32'(e_to));
  endtask

  task automatic feed(input logic [1:0] c, input logic d, input logic e);
    cycle(1'b0, 1'b1, c, d, e);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic do_rst();
    cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic idle_until(input int target);
    for (int g = 0; g < 200 && cyc < target; g++) idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int scnt;
    rst = 1'b1;
    bus.i_evt_vld = 0; bus.i_cls = 0; bus.i_det = 0; bus.i_err = 0;
    bus.i_nleak = 0; bus.i_nleak_vld = 0; bus.i_est_busy = 0;
    model_reset();

    // Reset state.
    do_rst(); do_rst();
    chk("rst_nv", 32'(bus.o_nv), 0);
    chk("rst_start", 32'(bus.o_start), 0);
    chk("rst_nleak", bus.o_nleak, 0);

    // Reference block with an ignored class-11 pulse, leak = 5.
    kn_dl = 2; kn_db = 2; kn_h = 2; kn_to = 0; kn_leak_en = 1; kn_leak = 32'd5;
    feed(2'b01, 1, 0); feed(2'b01, 1, 1); feed(2'b10, 1, 0); feed(2'b10, 1, 1);
    feed(2'b00, 1, 1); feed(2'b00, 0, 0); feed(2'b11, 1, 1); feed(2'b10, 0, 0);
    feed(2'b01, 1, 0);
    chk("t1_nv", 32'(bus.o_nv), 3);
    chk("t1_nu", 32'(bus.o_nu), 2);
    chk("t1_no", 32'(bus.o_no), 1);
    chk("t1_mv", 32'(bus.o_mv), 1);
    chk("t1_mo", 32'(bus.o_mo), 1);
    chk("t1_ovf", 32'(bus.o_ovf), 0);
    idle();
    chk("t1_start_pre", 32'(bus.o_start), 0);
    idle();
    chk("t1_nleak", bus.o_nleak, 5);
    chk("t1_start_rise", 32'(bus.o_start), 1);
    scnt = 1;
    for (int i = 0; i < 8; i++) begin
      idle();
      if (bus.o_start) scnt++;
    end
    chk("t1_start_w", 32'(scnt), 4);
    kn_leak_en = 0;

    // Saturation of the narrowed counters, then a clean block.
    do_rst();
    kn_dl = 1; kn_db = 1; kn_h = 1;
    for (int i = 0; i < 8; i++) feed(2'b01, 1, 1);
    chk("sat_nv", 32'(bus.o_nv), MAXC);
    chk("sat_mv", 32'(bus.o_mv), MAXC);
    chk("sat_ovf", 32'(bus.o_ovf), 1);
    idle_until(F);
    for (int i = 0; i < 4; i++) feed(2'b01, 1, 0);
    for (int i = 0; i < 4; i++) feed(2'b10, 1, 0);
    chk("sat2_ovf", 32'(bus.o_ovf), 0);
    chk("sat2_nv", 32'(bus.o_nv), 4);
    chk("sat2_nu", 32'(bus.o_nu), 4);

    // Second block ends while the estimator is busy.
    do_rst();
    kn_dl = 1; kn_db = 1; kn_h = 40;
    for (int i = 0; i < 5; i++) feed(2'b10, 1, 0);
    for (int i = 0; i < 3; i++) feed(2'b00, 0, 0);
    idle();
    for (int i = 0; i < 7; i++) feed(2'b01, 1, 1);
    chk("drop_pre", 32'(bus.o_drop), 0);
    feed(2'b01, 1, 1);
    chk("drop_pulse", 32'(bus.o_drop), 1);
    chk("drop_nu", 32'(bus.o_nu), 5);
    chk("drop_nv", 32'(bus.o_nv), 0);
    idle();
    chk("drop_end", 32'(bus.o_drop), 0);

    // Estimator never raises busy.
    do_rst();
    kn_dl = 1; kn_to = 1;
    for (int i = 0; i < 2; i++) feed(2'b01, 1, 0);
    for (int i = 0; i < 6; i++) feed(2'b00, 0, 0);
    idle_until(L + SW + TO - 1);
    chk("to_early", 32'(bus.o_timeout), 0);
    idle();
    chk("to_pulse", 32'(bus.o_timeout), 1);
    kn_to = 0; kn_db = 1; kn_h = 1;
    for (int i = 0; i < 3; i++) feed(2'b10, 1, 0);
    for (int i = 0; i < 5; i++) feed(2'b00, 0, 0);
    chk("to_next_drop", 32'(bus.o_drop), 0);
    chk("to_next_nu", 32'(bus.o_nu), 3);
    chk("to_next_nv", 32'(bus.o_nv), 0);

    // Reset during the second start cycle.
    do_rst();
    kn_dl = 1; kn_db = 1; kn_h = 1;
    for (int i = 0; i < 8; i++) feed(2'b01, 1, 0);
    idle_until(L + 1);
    chk("rs_start_on", 32'(bus.o_start), 1);
    do_rst();
    chk("rs_start", 32'(bus.o_start), 0);
    chk("rs_nv", 32'(bus.o_nv), 0);
    chk("rs_nleak", bus.o_nleak, 0);
    for (int i = 0; i < 2; i++) feed(2'b00, 1, 1);
    for (int i = 0; i < 6; i++) feed(2'b00, 0, 0);
    chk("rs_no", 32'(bus.o_no), 2);
    chk("rs_mo", 32'(bus.o_mo), 2);

    // Event right after a block end belongs to the new block.
    do_rst();
    kn_dl = 1; kn_db = 1; kn_h = 1;
    for (int i = 0; i < 7; i++) feed(2'b00, 0, 0);
    feed(2'b01, 1, 0);
    chk("bd_old_nv", 32'(bus.o_nv), 1);
    chk("bd_old_nu", 32'(bus.o_nu), 0);
    feed(2'b10, 1, 0);
    for (int i = 0; i < 7; i++) feed(2'b00, 0, 0);
    chk("bd_new_nu", 32'(bus.o_nu), 1);
    chk("bd_new_nv", 32'(bus.o_nv), 0);

    // Randomized run with spurious leak strobes and occasional resets.
    do_rst();
    kn_dl = 0; kn_db = 0; kn_h = 0; kn_to = -1; spur_pct = 10;
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 999) < 3, $urandom_range(0, 99) < 80,
            2'($urandom_range(0, 3)), $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 30);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
